fifo72_rr_arbiter: RTL and testbench

Packet-granular round-robin arbiter that drains NPORTS 72-bit first-word-fall-through FIFO read ports (one per ingress lane) into one 72-bit downstream FIFO write port. It sits between the per-port xgmii2gmii clock-crossing FIFOs and the shared switch datapath. It never interleaves words of different frames, and it truncates and discards oversize frames. It also keeps frame and drop statistics.

---
 rtl/fifo72_rr_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_fifo72_rr_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo72_rr_arbiter.sv
// Packet-granular round-robin arbiter draining NPORTS FWFT FIFOs into one sink FIFO.
// Frames are never interleaved; oversize frames are truncated with a forced EOP and the rest discarded.
module fifo72_rr_arbiter #(
    parameter int unsigned NPORTS    = 2,
    parameter int unsigned MAX_WORDS = 192
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [72*NPORTS-1:0] src_dout,
    input  logic [NPORTS-1:0]    src_empty,
    output logic [NPORTS-1:0]    src_rd_en,
    output logic [71:0]          out_din,
    output logic                 out_wr_en,
    input  logic                 out_full,
    output logic [NPORTS-1:0]    grant,
    output logic                 busy,
    output logic                 err_oversize,
    output logic [31:0]          frame_cnt,
    output logic [15:0]          drop_cnt
);

    localparam int unsigned IdxW  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int unsigned WcntW = $clog2(MAX_WORDS + 1);
    localparam logic [WcntW-1:0] MaxWords = WcntW'(MAX_WORDS);

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StDiscard
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [IdxW-1:0]   last_q, last_d;
    logic [NPORTS-1:0] grant_q, grant_d;
    logic [WcntW-1:0]  wcnt_q, wcnt_d;
    logic [WcntW-1:0]  wcnt_inc;
    logic [71:0]       out_din_q, out_din_d;
    logic              out_wr_en_q, out_wr_en_d;
    logic              err_q, err_d;
    logic [31:0]       frame_cnt_q, frame_cnt_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic              found_hi, found_lo, found;
    logic [IdxW-1:0]   pick_hi, pick_lo, pick;
    logic [71:0]       word;
    logic              src_ne;
    logic              rd;

    // Round-robin pick: first requester above last, else the lowest requester overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int i = int'(NPORTS) - 1; i >= 0; i--) begin
            if (!src_empty[i]) begin
                found_lo = 1'b1;
                pick_lo  = IdxW'(i);
                if (i > int'(last_q)) begin
                    found_hi = 1'b1;
                    pick_hi  = IdxW'(i);
                end
            end
        end
        found = found_hi | found_lo;
        pick  = found_hi ? pick_hi : pick_lo;
    end

    always_comb begin
        word = '0;
        for (int i = 0; i < int'(NPORTS); i++) begin
            if (grant_q[i]) word = src_dout[72*i +: 72];
        end
    end

    assign src_ne = |(grant_q & ~src_empty);

    // Read strobe is gated by reset so nothing is pulled from a source during reset.
    always_comb begin
        rd = 1'b0;
        if (rst_n) begin
            case (state_q)
                StXfer:    rd = src_ne & ~out_full;
                StDiscard: rd = src_ne;
                default:   rd = 1'b0;
            endcase
        end
        src_rd_en = grant_q & {NPORTS{rd}};
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        grant_d     = grant_q;
        wcnt_d      = wcnt_q;
        out_din_d   = out_din_q;
        out_wr_en_d = 1'b0;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        wcnt_inc    = wcnt_q + 1'b1;
        case (state_q)
            StIdle: begin
                if (en && found) begin
                    state_d = StXfer;
                    owner_d = pick;
                    grant_d = {{(NPORTS-1){1'b0}}, 1'b1} << pick;
                    wcnt_d  = '0;
                end
            end
            StXfer: begin
                if (rd) begin
                    out_din_d   = word;
                    out_wr_en_d = 1'b1;
                    wcnt_d      = wcnt_inc;
                    if (word[71]) begin
                        state_d     = StIdle;
                        last_d      = owner_q;
                        grant_d     = '0;
                        frame_cnt_d = frame_cnt_q + 32'd1;
                    end else if (wcnt_inc == MaxWords) begin
                        out_din_d[71] = 1'b1;
                        err_d         = 1'b1;
                        frame_cnt_d   = frame_cnt_q + 32'd1;
                        drop_cnt_d    = drop_cnt_q + 16'd1;
                        state_d       = StDiscard;
                    end
                end
            end
            StDiscard: begin
                if (rd && word[71]) begin
                    state_d = StIdle;
                    last_d  = owner_q;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            last_q      <= IdxW'(NPORTS - 1);
            grant_q     <= '0;
            wcnt_q      <= '0;
            out_din_q   <= '0;
            out_wr_en_q <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            wcnt_q      <= wcnt_d;
            out_din_q   <= out_din_d;
            out_wr_en_q <= out_wr_en_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_din      = out_din_q;
    assign out_wr_en    = out_wr_en_q;
    assign grant        = grant_q;
    assign busy         = (state_q != StIdle);
    assign err_oversize = err_q;
    assign frame_cnt    = frame_cnt_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_fifo72_rr_arbiter.sv
// Self-checking bench for fifo72_rr_arbiter: reset/arbitration vector table, directed frame
// sequences and randomized traffic scored against a frame-level round-robin model.
module tb_fifo72_rr_arbiter;

    localparam int NP = 3;
    localparam int MW = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [72*NP-1:0] src_dout;
    logic [NP-1:0]   src_empty;
    logic [NP-1:0]   src_rd_en;
    logic [71:0]     out_din;
    logic            out_wr_en;
    logic            out_full;
    logic [NP-1:0]   grant;
    logic            busy;
    logic            err_oversize;
    logic [31:0]     frame_cnt;
    logic [15:0]     drop_cnt;

    always #5 clk = ~clk;

    fifo72_rr_arbiter #(
        .NPORTS    (NP),
        .MAX_WORDS (MW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .src_dout     (src_dout),
        .src_empty    (src_empty),
        .src_rd_en    (src_rd_en),
        .out_din      (out_din),
        .out_wr_en    (out_wr_en),
        .out_full     (out_full),
        .grant        (grant),
        .busy         (busy),
        .err_oversize (err_oversize),
        .frame_cnt    (frame_cnt),
        .drop_cnt     (drop_cnt)
    );

    typedef struct {
        logic [71:0] w;
        bit          err;
    } exp_t;

    typedef struct {
        bit          en;
        logic [NP-1:0] empty;
        bit          full;
        logic [NP-1:0] grant;
        bit          busy;
        logic [NP-1:0] rd;
    } vec_t;

    logic [71:0] srcq [NP][$];
    exp_t        expq [$];
    int          wr_log [$];
    logic [71:0] out_log [$];
    vec_t        vecs [9];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   fid_ctr = 0;
    int   full_mode, full_pct, hold_pct;
    bit   full_val, sb_on, full_rd_chk, prev_full, hold;
    logic [NP-1:0] prev_rd;
    int   first_rd, err_cnt, exp_frames, exp_drops;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [71:0] mkword(int port, int fid, int idx, bit eop);
        logic [71:0] w;
        w[71]    = eop;
        w[70:64] = 7'($urandom);
        w[63:56] = 8'(port);
        w[55:40] = 16'(fid);
        w[39:16] = 24'($urandom);
        w[15:0]  = 16'(idx);
        return w;
    endfunction

    task automatic add_frame(int port, int len);
        for (int i = 0; i < len; i++) srcq[port].push_back(mkword(port, fid_ctr, i, i == len - 1));
        fid_ctr++;
    endtask

    // Frame-level model: whole frames leave in round-robin order, truncated at MW words.
    task automatic build_expected();
        int pos [NP];
        int last, sel, n;
        bit found, done;
        logic [71:0] w;
        exp_t e;
        expq.delete();
        exp_frames = 0;
        exp_drops  = 0;
        last = NP - 1;
        foreach (pos[i]) pos[i] = 0;
        forever begin
            found = 0;
            sel   = 0;
            for (int k = NP; k >= 1; k--) begin
                if (pos[(last + k) % NP] < srcq[(last + k) % NP].size()) begin
                    found = 1;
                    sel   = (last + k) % NP;
                end
            end
            if (!found) break;
            n    = 0;
            done = 0;
            while (!done) begin
                w = srcq[sel][pos[sel]];
                pos[sel]++;
                n++;
                e.err = 0;
                if (w[71]) begin
                    e.w = w;
                    expq.push_back(e);
                    exp_frames++;
                    done = 1;
                end else if (n == MW) begin
                    w[71] = 1'b1;
                    e.w   = w;
                    e.err = 1;
                    expq.push_back(e);
                    exp_frames++;
                    exp_drops++;
                    while (!srcq[sel][pos[sel]][71]) pos[sel]++;
                    pos[sel]++;
                    done = 1;
                end else begin
                    e.w = w;
                    expq.push_back(e);
                end
            end
            last = sel;
        end
    endtask

    function automatic bit all_done();
        if (expq.size() != 0) return 0;
        for (int i = 0; i < NP; i++) if (srcq[i].size() != 0) return 0;
        return 1;
    endfunction

    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        case (full_mode)
            1:       out_full = ($urandom_range(99) < full_pct);
            2:       out_full = ((cyc / 2) % 2) == 1;
            default: out_full = full_val;
        endcase
        hold = ($urandom_range(99) < hold_pct);
        for (int i = 0; i < NP; i++) begin
            if (srcq[i].size() != 0 && !hold) begin
                src_empty[i]         = 1'b0;
                src_dout[72*i +: 72] = srcq[i][0];
            end else begin
                src_empty[i]         = 1'b1;
                src_dout[72*i +: 72] = '0;
            end
        end
        #1;
        chk("rd_onehot", ($countones(src_rd_en) <= 1), 1);
        chk("rd_in_grant", src_rd_en & ~grant, 0);
        chk("busy_grant", busy, (grant != 0));
        if (full_rd_chk && out_full) chk("rd_while_full", src_rd_en, 0);
        if (out_wr_en) begin
            chk("wr_latency", (prev_rd != 0), 1);
            chk("wr_after_full", prev_full, 0);
            wr_log.push_back(cyc);
            out_log.push_back(out_din);
            if (err_oversize) err_cnt++;
            if (sb_on) begin
                if (expq.size() == 0) begin
                    chk("unexpected_wr", out_wr_en, 0);
                end else begin
                    e = expq.pop_front();
                    chk("out_din", out_din, e.w);
                    chk("err_oversize", err_oversize, e.err);
                end
            end
        end else begin
            chk("err_no_wr", err_oversize, 0);
        end
        if (src_rd_en != 0 && first_rd < 0) first_rd = cyc;
        for (int i = 0; i < NP; i++) begin
            if (src_rd_en[i]) begin
                chk("rd_when_empty", src_empty[i], 0);
                if (srcq[i].size() != 0) void'(srcq[i].pop_front());
            end
        end
        prev_full = out_full;
        prev_rd   = src_rd_en;
    endtask

    task automatic do_reset();
        sb_on       = 0;
        full_rd_chk = 0;
        en          = 0;
        rst_n       = 0;
        full_mode   = 0;
        full_val    = 0;
        hold_pct    = 0;
        for (int i = 0; i < NP; i++) srcq[i].delete();
        expq.delete();
        step();
        step();
        rst_n = 1;
        wr_log.delete();
        out_log.delete();
        first_rd = -1;
        err_cnt  = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_src_rd_en"}, src_rd_en, 0);
        chk({tag, "_out_wr_en"}, out_wr_en, 0);
        chk({tag, "_out_din"}, out_din, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err_oversize, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
        chk({tag, "_drop_cnt"}, drop_cnt, 0);
    endtask

    task automatic run_until_done(input string name, input int budget);
        int n;
        n = 0;
        while (!all_done() && n < budget) begin
            step();
            n++;
        end
        chk({name, "_drained"}, all_done(), 1);
        step();
        step();
        chk({name, "_frame_cnt"}, frame_cnt, exp_frames);
        chk({name, "_drop_cnt"}, drop_cnt, exp_drops);
        chk({name, "_err_pulses"}, err_cnt, exp_drops);
        chk({name, "_grant_idle"}, grant, 0);
        chk({name, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n     = 0;
        en        = 0;
        out_full  = 0;
        src_empty = '1;
        src_dout  = '0;
        prev_full = 0;
        prev_rd   = '0;
        hold      = 0;
        full_pct  = 0;

        //            en  empty   full grant   busy rd
        vecs[0] = '{1'b1, 3'b111, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[1] = '{1'b1, 3'b110, 1'b0, 3'b001, 1'b1, 3'b001};
        vecs[2] = '{1'b1, 3'b101, 1'b0, 3'b010, 1'b1, 3'b010};
        vecs[3] = '{1'b1, 3'b011, 1'b0, 3'b100, 1'b1, 3'b100};
        vecs[4] = '{1'b1, 3'b000, 1'b0, 3'b001, 1'b1, 3'b001};
        vecs[5] = '{1'b1, 3'b001, 1'b0, 3'b010, 1'b1, 3'b010};
        vecs[6] = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[7] = '{1'b1, 3'b000, 1'b1, 3'b001, 1'b1, 3'b000};
        vecs[8] = '{1'b1, 3'b011, 1'b1, 3'b100, 1'b1, 3'b000};

        do_reset();
        chk_reset_vals("reset");

        for (int v = 0; v < 9; v++) begin
            do_reset();
            for (int i = 0; i < NP; i++) if (!vecs[v].empty[i]) add_frame(i, 2);
            en       = vecs[v].en;
            full_val = vecs[v].full;
            step();
            step();
            chk($sformatf("vec%0d_grant", v), grant, vecs[v].grant);
            chk($sformatf("vec%0d_busy", v), busy, vecs[v].busy);
            chk($sformatf("vec%0d_rd", v), src_rd_en, vecs[v].rd);
        end

        // Single 4-word frame: back-to-back writes one cycle behind the reads.
        do_reset();
        add_frame(0, 4);
        build_expected();
        sb_on = 1;
        en    = 1;
        run_until_done("single", 100);
        chk("single_nwr", wr_log.size(), 4);
        for (int k = 0; k < wr_log.size(); k++) chk("single_wr_cyc", wr_log[k], first_rd + 1 + k);
        if (out_log.size() == 4) chk("single_eop", out_log[3][71], 1);

        // Fairness: two ports with 3-word frames alternate, one bubble between frames.
        do_reset();
        for (int f = 0; f < 3; f++) begin
            add_frame(0, 3);
            add_frame(1, 3);
        end
        build_expected();
        sb_on = 1;
        en    = 1;
        run_until_done("fair", 200);
        chk("fair_nwr", wr_log.size(), 18);
        if (wr_log.size() == 18) begin
            for (int j = 0; j < 6; j++) begin
                chk("fair_owner", out_log[3*j][63:56], j % 2);
                chk("fair_contig", wr_log[3*j+2] - wr_log[3*j], 2);
                if (j > 0) chk("fair_bubble", wr_log[3*j] - wr_log[3*j-1], 2);
            end
        end

        // Backpressure: out_full toggles every 2 cycles during a 10-word frame.
        do_reset();
        add_frame(0, 10);
        build_expected();
        sb_on       = 1;
        full_rd_chk = 1;
        full_mode   = 2;
        en          = 1;
        run_until_done("bp", 200);
        chk("bp_nwr", wr_log.size(), 10);
        for (int k = 0; k < out_log.size(); k++) chk("bp_order", out_log[k][15:0], k);

        // Oversize: exact-MW frame passes, MW+3 frame truncated, following frame intact.
        do_reset();
        add_frame(0, MW);
        add_frame(1, MW + 3);
        add_frame(1, 2);
        build_expected();
        sb_on = 1;
        en    = 1;
        run_until_done("ovs", 300);
        chk("ovs_nwr", wr_log.size(), 2 * MW + 2);
        if (out_log.size() == 2 * MW + 2) begin
            chk("ovs_forced_eop", out_log[2*MW-1][71], 1);
            chk("ovs_exact_eop", out_log[MW-1][71], 1);
        end
        chk("ovs_frames", frame_cnt, 3);
        chk("ovs_drops", drop_cnt, 1);

        // en low blocks grants; reset mid-frame aborts and restores port-0 priority.
        do_reset();
        add_frame(0, 1);
        add_frame(0, 6);
        add_frame(1, 6);
        for (int k = 0; k < 4; k++) step();
        chk("en0_grant", grant, 0);
        chk("en0_busy", busy, 0);
        chk("en0_noread", srcq[0].size() + srcq[1].size(), 13);
        en = 1;
        n  = 0;
        while (wr_log.size() < 3 && n < 50) begin
            step();
            n++;
        end
        chk("enrst_progress", wr_log.size(), 3);
        chk("pre_rst_frames", frame_cnt, 1);
        chk("pre_rst_grant", grant, 3'b010);
        rst_n = 0;
        step();
        chk_reset_vals("midrst");
        for (int i = 0; i < NP; i++) srcq[i].delete();
        add_frame(0, 2);
        add_frame(1, 2);
        rst_n = 1;
        step();
        step();
        chk("post_rst_grant", grant, 3'b001);

        // Randomized traffic with source stalls and sink backpressure.
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int i = 0; i < NP; i++) begin
                n = $urandom_range(4);
                for (int f = 0; f < n; f++) add_frame(i, $urandom_range(MW + 4, 1));
            end
            build_expected();
            sb_on     = 1;
            full_mode = 1;
            full_pct  = 30;
            hold_pct  = 20;
            en        = 1;
            run_until_done($sformatf("rand%0d", it), 3000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
